// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the ZAP bus arbiter: CTI encodings and grant state.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CODE = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/zap_wb_arb_pick.sv
// Next-grant selection for zap_wb_arb. The owner keeps the bus while it still requests;
// an IDLE tie goes to DATA unless last_code_s says DATA was served last.
module zap_wb_arb_pick
    import zap_wb_pkg::*;
(
    input  arb_state_t state_ff,
    input  logic       decide_s,
    input  logic       c_cyc_s,
    input  logic       d_cyc_s,
    input  logic       last_code_s,
    output arb_state_t state_nxt
);

    // Grant decision, only taken when the bus is free or finishing a beat.
    always_comb begin
        state_nxt = state_ff;
        if (decide_s) begin
            case (state_ff)
                CODE: begin
                    if (c_cyc_s)      state_nxt = CODE;
                    else if (d_cyc_s) state_nxt = DATA;
                    else              state_nxt = IDLE;
                end
                DATA: begin
                    if (d_cyc_s)      state_nxt = DATA;
                    else if (c_cyc_s) state_nxt = CODE;
                    else              state_nxt = IDLE;
                end
                default: begin
                    if (c_cyc_s && d_cyc_s) state_nxt = last_code_s ? DATA : CODE;
                    else if (d_cyc_s)       state_nxt = DATA;
                    else if (c_cyc_s)       state_nxt = CODE;
                    else                    state_nxt = IDLE;
                end
            endcase
        end else begin
            state_nxt = state_ff;
        end
    end

endmodule

// File: rtl/zap_wb_arb.sv
// Two-master (code cache / data cache) Wishbone B3 arbiter with a registered bus.
// Define ZAP_WB_ARB_RR_EN for round-robin tie breaking; default is DATA-over-CODE priority.
module zap_wb_arb
    import zap_wb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_c_wb_cyc_nxt,
    input  logic        i_c_wb_stb_nxt,
    input  logic        i_c_wb_wen_nxt,
    input  logic [3:0]  i_c_wb_sel_nxt,
    input  logic [31:0] i_c_wb_adr_nxt,
    input  logic [31:0] i_c_wb_dat_nxt,
    input  logic [2:0]  i_c_wb_cti_nxt,
    output logic        o_c_wb_ack,

    input  logic        i_d_wb_cyc_nxt,
    input  logic        i_d_wb_stb_nxt,
    input  logic        i_d_wb_wen_nxt,
    input  logic [3:0]  i_d_wb_sel_nxt,
    input  logic [31:0] i_d_wb_adr_nxt,
    input  logic [31:0] i_d_wb_dat_nxt,
    input  logic [2:0]  i_d_wb_cti_nxt,
    output logic        o_d_wb_ack,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack
);

    arb_state_t state_ff;
    arb_state_t state_nxt;
    logic       decide_s;
    logic       last_code_s;

    // The grant may only move when no beat is outstanding or the current one is acked.
    assign decide_s = !o_wb_stb || i_wb_ack;

`ifdef ZAP_WB_ARB_RR_EN
    logic last_code_r;

    // Remember which master was granted most recently for IDLE tie breaking.
    always_ff @(posedge i_clk) begin
        if (i_reset)                last_code_r <= 1'b1;
        else if (state_nxt == CODE) last_code_r <= 1'b1;
        else if (state_nxt == DATA) last_code_r <= 1'b0;
        else                        last_code_r <= last_code_r;
    end

    assign last_code_s = last_code_r;
`else
    assign last_code_s = 1'b1;
`endif

    zap_wb_arb_pick u_pick (
        .state_ff    (state_ff),
        .decide_s    (decide_s),
        .c_cyc_s     (i_c_wb_cyc_nxt),
        .d_cyc_s     (i_d_wb_cyc_nxt),
        .last_code_s (last_code_s),
        .state_nxt   (state_nxt)
    );

    // Grant state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_ff <= IDLE;
        else         state_ff <= state_nxt;
    end

    // Register the selected master's next-cycle bundle onto the external bus.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= 4'd0;
            o_wb_adr <= 32'd0;
            o_wb_dat <= 32'd0;
            o_wb_cti <= CTI_EOB;
        end else begin
            case (state_nxt)
                CODE: begin
                    o_wb_cyc <= i_c_wb_cyc_nxt;
                    o_wb_stb <= i_c_wb_stb_nxt;
                    o_wb_wen <= i_c_wb_wen_nxt;
                    o_wb_sel <= i_c_wb_sel_nxt;
                    o_wb_adr <= i_c_wb_adr_nxt;
                    o_wb_dat <= i_c_wb_dat_nxt;
                    o_wb_cti <= i_c_wb_cti_nxt;
                end
                DATA: begin
                    o_wb_cyc <= i_d_wb_cyc_nxt;
                    o_wb_stb <= i_d_wb_stb_nxt;
                    o_wb_wen <= i_d_wb_wen_nxt;
                    o_wb_sel <= i_d_wb_sel_nxt;
                    o_wb_adr <= i_d_wb_adr_nxt;
                    o_wb_dat <= i_d_wb_dat_nxt;
                    o_wb_cti <= i_d_wb_cti_nxt;
                end
                default: begin
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                    o_wb_wen <= 1'b0;
                    o_wb_sel <= 4'd0;
                    o_wb_adr <= 32'd0;
                    o_wb_dat <= 32'd0;
                    o_wb_cti <= CTI_EOB;
                end
            endcase
        end
    end

    // Acks only reach the owner of a live beat; spurious acks are dropped.
    assign o_c_wb_ack = i_wb_ack && o_wb_stb && (state_ff == CODE);
    assign o_d_wb_ack = i_wb_ack && o_wb_stb && (state_ff == DATA);

endmodule

// File: tb/tb_zap_wb_arb.sv
// Self-checking bench for zap_wb_arb: directed scenarios plus randomized traffic against
// a transaction-level model of ownership, hand-over and ack routing.
module tb_zap_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_cyc, c_stb, c_wen, d_cyc, d_stb, d_wen;
    logic [3:0]  c_sel, d_sel;
    logic [31:0] c_adr, c_dat, d_adr, d_dat;
    logic [2:0]  c_cti, d_cti;
    logic        wb_ack;

    logic        o_c_wb_ack, o_d_wb_ack;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [2:0]  o_wb_cti;

    int vec_cnt = 0;
    int err_cnt = 0;
    int c_seen  = 0;
    int d_seen  = 0;

`ifdef ZAP_WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Model: who owns the bus (0 none, 1 code, 2 data), what the bus shows, who was served last.
    int          m_owner     = 0;
    logic        m_cyc       = 1'b0;
    logic        m_stb       = 1'b0;
    logic        m_wen       = 1'b0;
    logic [3:0]  m_sel       = 4'd0;
    logic [31:0] m_adr       = 32'd0;
    logic [31:0] m_dat       = 32'd0;
    logic [2:0]  m_cti       = 3'b111;
    bit          m_last_code = 1'b1;

    always #5 clk = ~clk;

    zap_wb_arb dut (
        .i_clk(clk), .i_reset(rst),
        .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_wen_nxt(c_wen),
        .i_c_wb_sel_nxt(c_sel), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
        .i_c_wb_cti_nxt(c_cti), .o_c_wb_ack(o_c_wb_ack),
        .i_d_wb_cyc_nxt(d_cyc), .i_d_wb_stb_nxt(d_stb), .i_d_wb_wen_nxt(d_wen),
        .i_d_wb_sel_nxt(d_sel), .i_d_wb_adr_nxt(d_adr), .i_d_wb_dat_nxt(d_dat),
        .i_d_wb_cti_nxt(d_cti), .o_d_wb_ack(o_d_wb_ack),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
        .o_wb_sel(o_wb_sel), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
        .o_wb_cti(o_wb_cti), .i_wb_ack(wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        c_cyc = 1'b0; c_stb = 1'b0; c_wen = 1'b0; c_sel = 4'd0; c_adr = 32'd0; c_dat = 32'd0; c_cti = 3'b000;
        d_cyc = 1'b0; d_stb = 1'b0; d_wen = 1'b0; d_sel = 4'd0; d_adr = 32'd0; d_dat = 32'd0; d_cti = 3'b000;
        wb_ack = 1'b0;
        rst = 1'b0;
    endtask

    // One bus cycle: check acks against current inputs, clock, then check the registered bus.
    task automatic step();
        int   nxt;
        logic ec, ed;
        #1;
        ec = wb_ack && m_stb && (m_owner == 1);
        ed = wb_ack && m_stb && (m_owner == 2);
        chk("c_ack", 32'(o_c_wb_ack), 32'(ec));
        chk("d_ack", 32'(o_d_wb_ack), 32'(ed));
        c_seen += int'(o_c_wb_ack);
        d_seen += int'(o_d_wb_ack);
        nxt = m_owner;
        if (!m_stb || wb_ack) begin
            if (m_owner == 1 && c_cyc)      nxt = 1;
            else if (m_owner == 2 && d_cyc) nxt = 2;
            else if (c_cyc && d_cyc)        nxt = (RR && !m_last_code) ? 1 : 2;
            else if (d_cyc)                 nxt = 2;
            else if (c_cyc)                 nxt = 1;
            else                            nxt = 0;
        end
        if (rst) nxt = 0;
        @(posedge clk);
        #1;
        m_owner = nxt;
        if (rst)            m_last_code = 1'b1;
        else if (nxt == 1)  m_last_code = 1'b1;
        else if (nxt == 2)  m_last_code = 1'b0;
        if (nxt == 1) begin
            m_cyc = c_cyc; m_stb = c_stb; m_wen = c_wen; m_sel = c_sel; m_adr = c_adr; m_dat = c_dat; m_cti = c_cti;
        end else if (nxt == 2) begin
            m_cyc = d_cyc; m_stb = d_stb; m_wen = d_wen; m_sel = d_sel; m_adr = d_adr; m_dat = d_dat; m_cti = d_cti;
        end else begin
            m_cyc = 1'b0; m_stb = 1'b0; m_wen = 1'b0; m_sel = 4'd0; m_adr = 32'd0; m_dat = 32'd0; m_cti = 3'b111;
        end
        chk("cyc", 32'(o_wb_cyc), 32'(m_cyc));
        chk("stb", 32'(o_wb_stb), 32'(m_stb));
        chk("wen", 32'(o_wb_wen), 32'(m_wen));
        chk("sel", 32'(o_wb_sel), 32'(m_sel));
        chk("adr", o_wb_adr, m_adr);
        chk("dat", o_wb_dat, m_dat);
        chk("cti", 32'(o_wb_cti), 32'(m_cti));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_cti", 32'(o_wb_cti), 32'd7);
        rst = 1'b0;

        // Code read of 0x100 with two wait states.
        c_seen = 0; d_seen = 0;
        c_cyc = 1'b1; c_stb = 1'b1; c_sel = 4'hF; c_adr = 32'h100; c_cti = 3'b000;
        step();
        chk("r028_adr", o_wb_adr, 32'h100);
        step();
        step();
        wb_ack = 1'b1; c_cyc = 1'b0; c_stb = 1'b0;
        step();
        wb_ack = 1'b0;
        step();
        chk("r028_cack_cnt", 32'(c_seen), 32'd1);
        chk("r028_dack_cnt", 32'(d_seen), 32'd0);

        // Simultaneous request: DATA first, CODE starts right after DATA's last ack.
        c_cyc = 1'b1; c_stb = 1'b1; c_adr = 32'h200;
        d_cyc = 1'b1; d_stb = 1'b1; d_wen = 1'b1; d_sel = 4'h3; d_adr = 32'h300; d_dat = 32'hCAFE_F00D;
        step();
        chk("r029_first_adr", o_wb_adr, 32'h300);
        step();
        wb_ack = 1'b1; d_cyc = 1'b0; d_stb = 1'b0; d_wen = 1'b0;
        step();
        chk("r029_hand_adr", o_wb_adr, 32'h200);
        chk("r029_hand_cyc", 32'(o_wb_cyc), 32'd1);
        c_cyc = 1'b0; c_stb = 1'b0;
        step();
        wb_ack = 1'b0;
        step();

        // Eight-beat code burst; data requests from beat 2 and waits for the end.
        c_seen = 0; d_seen = 0;
        c_cyc = 1'b1; c_stb = 1'b1; c_adr = 32'h1000; c_cti = 3'b010;
        step();
        for (int k = 0; k < 8; k++) begin
            wb_ack = 1'b1;
            if (k >= 1) begin
                d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h400; d_wen = 1'b0;
            end
            if (k < 7) begin
                c_adr = 32'h1000 + 32'(4 * (k + 1));
                c_cti = (k == 6) ? 3'b111 : 3'b010;
            end else begin
                c_cyc = 1'b0; c_stb = 1'b0;
            end
            step();
            if (k < 7) chk("r030_beat_adr", o_wb_adr, 32'h1000 + 32'(4 * (k + 1)));
        end
        chk("r030_data_adr", o_wb_adr, 32'h400);
        chk("r030_cack_cnt", 32'(c_seen), 32'd8);
        d_cyc = 1'b0; d_stb = 1'b0;
        step();
        wb_ack = 1'b0;
        step();

        // Reset during a data write, then a spurious ack while the bus is idle.
        d_cyc = 1'b1; d_stb = 1'b1; d_wen = 1'b1; d_adr = 32'h500; d_dat = 32'h1234_5678;
        step();
        rst = 1'b1;
        step();
        chk("r032_cyc", 32'(o_wb_cyc), 32'd0);
        chk("r032_cti", 32'(o_wb_cti), 32'd7);
        idle_inputs();
        wb_ack = 1'b1;
        step();
        chk("r033_cyc", 32'(o_wb_cyc), 32'd0);
        wb_ack = 1'b0;

`ifdef ZAP_WB_ARB_RR_EN
        // Two ties from IDLE alternate the winner.
        c_cyc = 1'b1; c_stb = 1'b1; c_adr = 32'h600;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h700;
        step();
        chk("r031_first", o_wb_adr, 32'h700);
        wb_ack = 1'b1; c_cyc = 1'b0; c_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        step();
        wb_ack = 1'b0;
        c_cyc = 1'b1; c_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        step();
        chk("r031_second", o_wb_adr, 32'h600);
        idle_inputs();
        step();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(99) == 0);
            c_cyc  = ($urandom_range(2) != 0);
            c_stb  = c_cyc & ($urandom_range(3) != 0);
            c_wen  = 1'($urandom);
            c_sel  = 4'($urandom);
            c_adr  = $urandom;
            c_dat  = $urandom;
            c_cti  = 3'($urandom);
            d_cyc  = ($urandom_range(2) != 0);
            d_stb  = d_cyc & ($urandom_range(3) != 0);
            d_wen  = 1'($urandom);
            d_sel  = 4'($urandom);
            d_adr  = $urandom;
            d_dat  = $urandom;
            d_cti  = 3'($urandom);
            wb_ack = ($urandom_range(2) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
